// File: rtl/theremin_ctrl_pkg.sv
// theremin_ctrl_pkg: shared constants and types for the theremin SPI control port
package theremin_ctrl_pkg;

    localparam int FRAME_BITS = 24;

    typedef enum logic [3:0] {
        ADDR_A16    = 4'd0,
        ADDR_A8     = 4'd1,
        ADDR_A5     = 4'd2,
        ADDR_A4     = 4'd3,
        ADDR_BLEND  = 4'd4,
        ADDR_DELAY  = 4'd5,
        ADDR_FEEDBK = 4'd6
    } ctrl_addr_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } state_e;

    localparam int RST_A16    = 7;
    localparam int RST_A8     = 0;
    localparam int RST_A5     = 0;
    localparam int RST_A4     = 0;
    localparam int RST_BLEND  = 0;
    localparam int RST_DELAY  = 0;
    localparam int RST_FEEDBK = 0;

endpackage

// File: rtl/ctrl_sync.sv
// ctrl_sync: 2-flop synchronizer plus one history flop giving level, rise and fall pulses
module ctrl_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_100,
    input  logic reset_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [2:0] sr;

    // sr[0..1] synchronize the pin, sr[2] remembers the previous synchronized level
    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) sr <= {3{RST_VAL}};
        else          sr <= {sr[1:0], din};
    end

    assign level = sr[1];
    assign rise  = sr[1] & ~sr[2];
    assign fall  = ~sr[1] & sr[2];

endmodule

// File: rtl/ctrl_spi_rx.sv
// ctrl_spi_rx: oversampling SPI-slave receiver that decodes 24-bit write frames into control registers.
// Define CTRL_SPI_PARITY_EN to require even parity over the whole frame (bit 19 is the parity bit).
module ctrl_spi_rx #(
    parameter int FRAME_BITS = theremin_ctrl_pkg::FRAME_BITS,
    parameter int A_BITS     = 3,
    parameter int BLEND_B    = 4,
    parameter int DLY_B      = 14,
    parameter int FDB_B      = 10
) (
    input  logic               clk_100,
    input  logic               reset_n,
    input  logic               ctrl_sclk,
    input  logic               ctrl_mosi,
    input  logic               ctrl_ss_n,
    output logic [A_BITS-1:0]  a16,
    output logic [A_BITS-1:0]  a8,
    output logic [A_BITS-1:0]  a5,
    output logic [A_BITS-1:0]  a4,
    output logic [BLEND_B-1:0] blend,
    output logic [DLY_B-1:0]   delay,
    output logic [FDB_B-1:0]   feedbk,
    output logic               upd_valid,
    output logic [3:0]         upd_addr,
    output logic               frame_err
);

    import theremin_ctrl_pkg::*;

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;
    logic ss_lvl, ss_rise, ss_fall;

    ctrl_sync #(.RST_VAL(1'b0)) u_sclk (.clk_100(clk_100), .reset_n(reset_n), .din(ctrl_sclk),
                                        .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
    ctrl_sync #(.RST_VAL(1'b0)) u_mosi (.clk_100(clk_100), .reset_n(reset_n), .din(ctrl_mosi),
                                        .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall));
    ctrl_sync #(.RST_VAL(1'b1)) u_ss   (.clk_100(clk_100), .reset_n(reset_n), .din(ctrl_ss_n),
                                        .level(ss_lvl), .rise(ss_rise), .fall(ss_fall));

    state_e                state;
    logic [4:0]            bit_cnt;
    logic [FRAME_BITS-1:0] shreg;
    logic [3:0]            addr;
    logic [15:0]           data;
    logic                  par_ok;
    logic                  commit;
    logic                  unused;

    assign addr = shreg[FRAME_BITS-1 -: 4];
    assign data = shreg[15:0];
`ifdef CTRL_SPI_PARITY_EN
    assign par_ok = ~^shreg;
`else
    assign par_ok = 1'b1;
`endif
    assign commit = (bit_cnt == 5'(FRAME_BITS)) && (addr <= ADDR_FEEDBK) && par_ok;
    assign unused = ^{sclk_lvl, sclk_fall, mosi_rise, mosi_fall, ss_lvl, shreg[FRAME_BITS-5:16]};

    // frame FSM; registers and strobes all change together on the CHECK exit edge
    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            a16       <= A_BITS'(RST_A16);
            a8        <= A_BITS'(RST_A8);
            a5        <= A_BITS'(RST_A5);
            a4        <= A_BITS'(RST_A4);
            blend     <= BLEND_B'(RST_BLEND);
            delay     <= DLY_B'(RST_DELAY);
            feedbk    <= FDB_B'(RST_FEEDBK);
            upd_valid <= 1'b0;
            upd_addr  <= '0;
            frame_err <= 1'b0;
        end else begin
            upd_valid <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: if (ss_fall) begin
                    bit_cnt <= '0;
                    shreg   <= '0;
                    state   <= SHIFT;
                end
                SHIFT: if (ss_rise) begin
                    state <= CHECK;
                end else if (sclk_rise) begin
                    shreg   <= {shreg[FRAME_BITS-2:0], mosi_lvl};
                    bit_cnt <= (bit_cnt == 5'd31) ? bit_cnt : bit_cnt + 5'd1;
                end
                CHECK: begin
                    state <= IDLE;
                    if (commit) begin
                        upd_valid <= 1'b1;
                        upd_addr  <= addr;
                        case (ctrl_addr_e'(addr))
                            ADDR_A16:    a16    <= data[A_BITS-1:0];
                            ADDR_A8:     a8     <= data[A_BITS-1:0];
                            ADDR_A5:     a5     <= data[A_BITS-1:0];
                            ADDR_A4:     a4     <= data[A_BITS-1:0];
                            ADDR_BLEND:  blend  <= data[BLEND_B-1:0];
                            ADDR_DELAY:  delay  <= data[DLY_B-1:0];
                            ADDR_FEEDBK: feedbk <= data[FDB_B-1:0];
                            default: ;
                        endcase
                    end else begin
                        frame_err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_spi_rx.sv
// tb_ctrl_spi_rx: directed SPI frames with a scoreboard of expected update/error events
module tb_ctrl_spi_rx;

    logic        clk_100 = 1'b0;
    logic        reset_n = 1'b0;
    logic        ctrl_sclk = 1'b0;
    logic        ctrl_mosi = 1'b0;
    logic        ctrl_ss_n = 1'b1;
    logic [2:0]  a16, a8, a5, a4;
    logic [3:0]  blend;
    logic [13:0] delay;
    logic [9:0]  feedbk;
    logic        upd_valid;
    logic [3:0]  upd_addr;
    logic        frame_err;

    ctrl_spi_rx dut (
        .clk_100(clk_100), .reset_n(reset_n),
        .ctrl_sclk(ctrl_sclk), .ctrl_mosi(ctrl_mosi), .ctrl_ss_n(ctrl_ss_n),
        .a16(a16), .a8(a8), .a5(a5), .a4(a4),
        .blend(blend), .delay(delay), .feedbk(feedbk),
        .upd_valid(upd_valid), .upd_addr(upd_addr), .frame_err(frame_err)
    );

    always #5 clk_100 = ~clk_100;

    typedef struct packed {
        logic        err;
        logic [3:0]  addr;
        logic [39:0] regs;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0;
    int n_bad = 0;

    logic [2:0]  m_a16 = 3'd7, m_a8 = '0, m_a5 = '0, m_a4 = '0;
    logic [3:0]  m_blend = '0;
    logic [13:0] m_delay = '0;
    logic [9:0]  m_feedbk = '0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, want);
        end
    endtask

    function automatic logic [39:0] model_regs();
        return {m_a16, m_a8, m_a5, m_a4, m_blend, m_delay, m_feedbk};
    endfunction

    function automatic logic [23:0] par(input logic [23:0] f);
`ifdef CTRL_SPI_PARITY_EN
        return (^f) ? (f ^ 24'h080000) : f;
`else
        return f;
`endif
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_100);
        #1;
    endtask

    task automatic expect_ok(input logic [3:0] a, input logic [13:0] v);
        case (a)
            4'd0: m_a16 = v[2:0];
            4'd1: m_a8 = v[2:0];
            4'd2: m_a5 = v[2:0];
            4'd3: m_a4 = v[2:0];
            4'd4: m_blend = v[3:0];
            4'd5: m_delay = v;
            4'd6: m_feedbk = v[9:0];
            default: ;
        endcase
        q.push_back('{err: 1'b0, addr: a, regs: model_regs()});
    endtask

    task automatic expect_err();
        q.push_back('{err: 1'b1, addr: 4'd0, regs: model_regs()});
    endtask

    // sends the low n bits of v MSB first; stops with ss_n still low after 'stop' bits if stop < n
    task automatic spi_frame(input logic [31:0] v, input int n, input int stop);
        ctrl_ss_n = 1'b0;
        wait_cyc(5);
        for (int i = n - 1; i >= 0; i--) begin
            if (n - 1 - i == stop) return;
            ctrl_mosi = v[i];
            wait_cyc(5);
            ctrl_sclk = 1'b1;
            wait_cyc(5);
            ctrl_sclk = 1'b0;
        end
        wait_cyc(5);
        ctrl_ss_n = 1'b1;
        wait_cyc(12);
    endtask

    task automatic check_reset_state(input string nm);
        chk({nm, "_regs"}, {a16, a8, a5, a4, blend, delay, feedbk}, {3'd7, 37'd0});
        chk({nm, "_upd_valid"}, upd_valid, 0);
        chk({nm, "_frame_err"}, frame_err, 0);
        chk({nm, "_upd_addr"}, upd_addr, 0);
    endtask

    // monitor: every strobe must match the oldest expected event
    always @(negedge clk_100) begin
        if (reset_n && (upd_valid || frame_err)) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_event: upd_valid=%0b frame_err=%0b expected none", upd_valid, frame_err);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("ev_upd_valid", upd_valid, !e.err);
                chk("ev_frame_err", frame_err, e.err);
                if (!e.err) chk("ev_upd_addr", upd_addr, e.addr);
                chk("ev_regs", {a16, a8, a5, a4, blend, delay, feedbk}, e.regs);
            end
        end
    end

    initial begin
        wait_cyc(3);
        check_reset_state("reset_hold");
        reset_n = 1'b1;
        wait_cyc(5);
        check_reset_state("after_reset");

        expect_ok(4'd5, 14'h1234);
        spi_frame({8'h0, par(24'h501234)}, 24, 99);

        expect_ok(4'd4, 14'h000A);
        spi_frame({8'h0, par(24'h40000A)}, 24, 99);
        expect_err();
        spi_frame({8'h0, par(24'h400005)} >> 1, 23, 99);

        expect_err();
        spi_frame({8'h0, par(24'h900055)}, 24, 99);
        expect_err();
        spi_frame(32'h2A10_0002, 30, 99);

        expect_ok(4'd1, 14'h0002);
        spi_frame({8'h0, par(24'h100002)}, 24, 99);
        expect_ok(4'd2, 14'h0005);
        spi_frame({8'h0, par(24'h20FFFD)}, 24, 99);
        expect_ok(4'd3, 14'h0004);
        spi_frame({8'h0, par(24'h300004)}, 24, 99);
        expect_ok(4'd6, 14'h03CD);
        spi_frame({8'h0, par(24'h60ABCD)}, 24, 99);

        spi_frame({8'h0, par(24'h6003FF)}, 24, 12);
        reset_n = 1'b0;
        wait_cyc(2);
        ctrl_ss_n = 1'b1;
        ctrl_mosi = 1'b0;
        m_a16 = 3'd7; m_a8 = '0; m_a5 = '0; m_a4 = '0;
        m_blend = '0; m_delay = '0; m_feedbk = '0;
        check_reset_state("mid_frame_reset");
        wait_cyc(3);
        reset_n = 1'b1;
        wait_cyc(5);
        check_reset_state("post_mid_reset");
        expect_ok(4'd6, 14'h02AB);
        spi_frame({8'h0, par(24'h6002AB)}, 24, 99);

`ifdef CTRL_SPI_PARITY_EN
        expect_err();
        spi_frame(32'h0008_0003, 24, 99);
        expect_ok(4'd0, 14'h0003);
        spi_frame(32'h0000_0003, 24, 99);
`else
        expect_ok(4'd0, 14'h0003);
        spi_frame(32'h000F_0003, 24, 99);
`endif

        for (int i = 0; i < 4; i++) begin
            ctrl_sclk = 1'b1;
            wait_cyc(5);
            ctrl_sclk = 1'b0;
            wait_cyc(5);
        end
        wait_cyc(10);
        chk("queue_drained", q.size(), 0);
        chk("final_regs", {a16, a8, a5, a4, blend, delay, feedbk}, model_regs());
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
